// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor sizing, BTB FSM encoding and PC index/tag slicing.
package bp_pkg;
    localparam int BTB_SIZE = 256;
    localparam int IDX_BITS = $clog2(BTB_SIZE);
    localparam int IDX_MSB  = IDX_BITS + 1;
    localparam int TAG_BITS = 32 - IDX_BITS - 2;
    typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} btb_state_e;
    function automatic logic [IDX_BITS-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_MSB:2];
    endfunction
    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_MSB+1];
    endfunction
endpackage

// File: rtl/btb_flush_ctrl.sv
// btb_flush_ctrl: post-reset invalidate sweep, one entry per cycle, then RUN until the next reset.
module btb_flush_ctrl import bp_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    output logic                clr_en,
    output logic [IDX_BITS-1:0] clr_idx
);
    btb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == FLUSH) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_BITS'(BTB_SIZE - 1)) state_d = RUN;
        end
    end
    assign ready   = (state_q == RUN) && !rst;
    assign clr_en  = (state_q == FLUSH) && !rst;
    assign clr_idx = cnt_q;
endmodule

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer producing the next fetch PC; defining BTB_STATS_EN
// adds saturating lookup/hit/taken-update counters.
module btb import bp_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        pred_taken,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        ready,
    output logic        hit,
    output logic [31:0] pred_target,
    output logic [31:0] next_pc
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_updates
`endif
);
    logic [BTB_SIZE-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [BTB_SIZE];
    logic [31:0]         tgt_q [BTB_SIZE];
    logic                clr_en, wr_en;
    logic [IDX_BITS-1:0] clr_idx, rd_idx, wr_idx;

    btb_flush_ctrl u_flush (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign rd_idx = pc_idx(if_pc);
    assign wr_idx = pc_idx(upd_pc);
    // Not-taken resolutions leave the entry alone; the history table owns direction.
    assign wr_en  = ready && upd_en && upd_taken;

    always_ff @(posedge clk) begin
        if (clr_en) valid_q[clr_idx] <= 1'b0;
        else if (wr_en) valid_q[wr_idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= pc_tag(upd_pc);
            tgt_q[wr_idx] <= upd_target;
        end
    end

    assign hit         = ready && valid_q[rd_idx] && (tag_q[rd_idx] == pc_tag(if_pc));
    assign pred_target = hit ? tgt_q[rd_idx] : 32'd0;
    assign next_pc     = (hit && pred_taken) ? pred_target : if_pc + 32'd4;

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, updates_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
            updates_q <= '0;
        end else begin
            lookups_q <= lookups_q + {31'd0, ready && ~&lookups_q};
            hits_q    <= hits_q + {31'd0, hit && ~&hits_q};
            updates_q <= updates_q + {31'd0, wr_en && ~&updates_q};
        end
    end
    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_updates = updates_q;
`endif
endmodule

// File: tb/tb_btb.sv
// tb_btb: directed table, reset/flush sequences and random traffic checked against a PC-level BTB model.
module tb_btb;
    logic        clk = 1'b0;
    logic        rst, pred_taken, upd_en, upd_taken, ready, hit;
    logic [31:0] if_pc, upd_pc, upd_target, pred_target, next_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_updates;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .pred_taken  (pred_taken),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .ready       (ready),
        .hit         (hit),
        .pred_target (pred_target),
        .next_pc     (next_pc)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits),
        .stat_updates (stat_updates)
`endif
    );

    // Model: each slot remembers the full PC and target of its last taken install.
    bit          m_valid [256];
    logic [31:0] m_pc    [256];
    logic [31:0] m_tgt   [256];
    int          m_left = 256;
    logic [31:0] m_lookups = 0, m_hits = 0, m_updates = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return !rst && m_left == 0 && m_valid[i] && (m_pc[i] >> 10) == (pc >> 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic cmp(input string nm);
        bit          e_hit = m_hit(if_pc);
        logic [31:0] e_tgt = e_hit ? m_tgt[idx_of(if_pc)] : 32'd0;
        chk({nm, ".ready"}, {31'd0, ready}, {31'd0, !rst && m_left == 0});
        chk({nm, ".hit"}, {31'd0, hit}, {31'd0, e_hit});
        chk({nm, ".pred_target"}, pred_target, e_tgt);
        chk({nm, ".next_pc"}, next_pc, (e_hit && pred_taken) ? e_tgt : if_pc + 32'd4);
`ifdef BTB_STATS_EN
        chk({nm, ".stat_lookups"}, stat_lookups, m_lookups);
        chk({nm, ".stat_hits"}, stat_hits, m_hits);
        chk({nm, ".stat_updates"}, stat_updates, m_updates);
`endif
    endtask

    task automatic model_tick();
        if (rst) begin
            m_left = 256;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_lookups = 0;
            m_hits = 0;
            m_updates = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
            if (m_hit(if_pc) && m_hits != 32'hFFFF_FFFF) m_hits++;
            if (upd_en && upd_taken) begin
                if (m_updates != 32'hFFFF_FFFF) m_updates++;
                m_valid[idx_of(upd_pc)] = 1'b1;
                m_pc[idx_of(upd_pc)]    = upd_pc;
                m_tgt[idx_of(upd_pc)]   = upd_target;
            end
        end
    endtask

    task automatic half1(input string nm);
        @(negedge clk);
        cmp(nm);
    endtask

    task automatic half2();
        @(posedge clk);
        #1;
        model_tick();
    endtask

    task automatic cycle(input string nm);
        half1(nm);
        half2();
    endtask

    task automatic set_in(input logic ue, input logic ut, input logic [31:0] upc,
                          input logic [31:0] utgt, input logic [31:0] pc, input logic pt);
        upd_en = ue; upd_taken = ut; upd_pc = upc; upd_target = utgt; if_pc = pc; pred_taken = pt;
    endtask

    // Counts cycles with ready low (junk updates offered), then spends one idle RUN cycle.
    task automatic wait_flush(output int n);
        n = 0;
        forever begin
            set_in(1'b1, 1'b1, $urandom, $urandom, $urandom, 1'b1);
            half1("flush");
            if (ready) break;
            n++;
            if (n > 400) break;
            half2();
        end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000, 1'b1);
        half2();
    endtask

    typedef struct {
        logic        ue, ut;
        logic [31:0] upc, utgt, pc;
        logic        pt, hit;
        logic [31:0] tgt, nxt;
    } vec_t;
    vec_t tbl [14];

    logic [31:0] pool [8];

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b1, 32'h40,  32'h100, 32'h40,  1'b1, 1'b0, 32'h0,   32'h44};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h40,  1'b1, 1'b1, 32'h100, 32'h100};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h40,  1'b0, 1'b1, 32'h100, 32'h44};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h440, 1'b1, 1'b0, 32'h0,   32'h444};
        tbl[4]  = '{1'b1, 1'b1, 32'h440, 32'h200, 32'h440, 1'b1, 1'b0, 32'h0,   32'h444};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h40,  1'b1, 1'b0, 32'h0,   32'h44};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h440, 1'b1, 1'b1, 32'h200, 32'h200};
        tbl[7]  = '{1'b1, 1'b1, 32'h80,  32'h300, 32'h80,  1'b1, 1'b0, 32'h0,   32'h84};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h80,  1'b1, 1'b1, 32'h300, 32'h300};
        tbl[9]  = '{1'b1, 1'b0, 32'h80,  32'h999, 32'h80,  1'b1, 1'b1, 32'h300, 32'h300};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,   32'h80,  1'b1, 1'b1, 32'h300, 32'h300};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   32'h0,   32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'hC0,  32'h500, 32'hC0,  1'b1, 1'b0, 32'h0,   32'hC4};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   32'h0,   32'hC0,  1'b1, 1'b0, 32'h0,   32'hC4};
        pool = '{32'h40, 32'h440, 32'h80, 32'h1080, 32'hFFFF_FFFC, 32'h3FC, 32'h8000_0040, 32'h7FC};

        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        cycle("reset");
        rst = 1'b0;
        wait_flush(n);
        chk("flush_len", n, 256);

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].ue, tbl[i].ut, tbl[i].upc, tbl[i].utgt, tbl[i].pc, tbl[i].pt);
            half1($sformatf("row%0d", i));
            chk($sformatf("row%0d.hit", i), {31'd0, hit}, {31'd0, tbl[i].hit});
            chk($sformatf("row%0d.tgt", i), pred_target, tbl[i].tgt);
            chk($sformatf("row%0d.nxt", i), next_pc, tbl[i].nxt);
            half2();
        end

        rst = 1'b1;
        cycle("rst_a");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            set_in(1'b1, 1'b1, $urandom, $urandom, $urandom, 1'b1);
            cycle("midflush");
        end
        rst = 1'b1;
        cycle("rst_b");
        rst = 1'b0;
        wait_flush(n);
        chk("flush_restart_len", n, 256);

        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), pool[$urandom_range(0, 7)],
                   $urandom, pool[$urandom_range(0, 7)], $urandom_range(0, 1));
            cycle("rand");
        end
        set_in(1'b1, 1'b1, 32'h80, 32'h300, 32'h440, 1'b1);
        cycle("preload80");
        set_in(1'b1, 1'b1, 32'h440, 32'h200, 32'h40, 1'b1);
        cycle("preload440");

        rst = 1'b1;
        cycle("rst_run");
        rst = 1'b0;
        wait_flush(n);
        chk("flush_run_len", n, 256);
        set_in(1'b1, 1'b1, 32'h40, 32'h100, 32'h80, 1'b1);
        half1("post_rst_80");
        chk("post_rst_80_miss", {31'd0, hit}, 32'd0);
        half2();
        set_in(1'b1, 1'b1, 32'h80, 32'h300, 32'h440, 1'b1);
        half1("post_rst_440");
        chk("post_rst_440_miss", {31'd0, hit}, 32'd0);
        half2();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b1);
        cycle("stat_h1");
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h80, 1'b0);
        cycle("stat_h2");
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b1);
        cycle("stat_h3");
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000, 1'b1);
            cycle("stat_miss");
        end
        @(negedge clk);
`ifdef BTB_STATS_EN
        chk("stat_lookups_10", stat_lookups, 32'd10);
        chk("stat_hits_3", stat_hits, 32'd3);
        chk("stat_updates_2", stat_updates, 32'd2);
`endif
        chk("final_ready", {31'd0, ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
